shift_ser: RTL

Parallel-in, serial-out shifter for the chapter-2 datapath. Accepts a W-bit word over a valid/ready handshake and shifts it out one bit per enable tick on `sout`. Signals completion with a one-cycle `done` pulse. Sits downstream of the enabled flip-flop register stage: a captured register word feeds `load_data`, and `e` is the shared enable/tick strobe.

---
 rtl/shift_ser_pkg.sv | 14 +
 rtl/shift_ser_if.sv | 25 ++
 rtl/shift_ser_bit_cnt.sv | 43 ++++
 rtl/shift_ser.sv | 119 +++++++++++
 4 files changed

// File: rtl/shift_ser_pkg.sv
// Shared definitions for the shift_ser parallel-in/serial-out block.
// Holds the state encoding and the idle level of the serial line.
package shift_ser_pkg;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_SHIFT  = 1'b1;
  localparam logic SOUT_IDLE = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } state_e;

endpackage

// File: rtl/shift_ser_if.sv
// Load handshake for shift_ser: an upstream word offered with valid/ready.
//   load_valid : upstream word available (master -> slave)
//   load_data  : W-bit word to serialise (master -> slave)
//   load_ready : slave can accept a word (slave -> master)
interface shift_ser_if #(
  parameter int unsigned W = 8
);

  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );

endinterface

// File: rtl/shift_ser_bit_cnt.sv
// Enabled, synchronously clearable bit counter for shift_ser.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr_i      : synchronous clear to zero (wins over e_i)
//   e_i        : advance one count; wraps to zero after W-1
//   cnt_o      : current count, 0 .. W-1
//   last_o     : high when cnt_o == W-1
module shift_ser_bit_cnt #(
  parameter int unsigned W    = 8,
  parameter int unsigned CntW = $clog2(W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            e_i,
  output logic [CntW-1:0] cnt_o,
  output logic            last_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(W - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == CntMax);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (e_i) begin
      cnt_d = last_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_ser.sv
// Parallel-in, serial-out shifter. Accepts a W-bit word over load_if and
// shifts it out on sout_o, one bit per e_i tick, then pulses done_o.
//   clk, rst_n : clock and asynchronous active-low reset
//   e_i        : shift tick, only honoured while shifting
//   clr_i      : synchronous abort back to idle, no done pulse
//   load_if    : valid/ready word handshake (slave side)
//   sout_o     : serial data, idles high
//   busy_o     : high while a word is being shifted
//   done_o     : one-cycle pulse once the last bit has completed
module shift_ser
  import shift_ser_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        e_i,
  input  logic        clr_i,
  shift_ser_if.slave  load_if,
  output logic        sout_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned     CntW   = $clog2(W);
  localparam logic [CntW-1:0] CntMax = CntW'(W - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    sr_q, sr_d;
  logic            sout_q, sout_d;
  logic            done_q, done_d;
  logic [CntW-1:0] cnt;
  logic            cnt_last;
  logic            cnt_en;
  logic            first_bit;
  logic            next_bit;
  logic [W-1:0]    sr_shifted;

  // The counter only advances on ticks taken while shifting; it wraps to zero
  // by itself on the last bit, so it is already zero for the next word.
  assign cnt_en = (state_q == StShift) && e_i;

  shift_ser_bit_cnt #(
    .W    (W),
    .CntW (CntW)
  ) u_bit_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr_i),
    .e_i    (cnt_en),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  // Output end of the register is bit 0 (LSB first) or bit W-1 (MSB first);
  // the register moves toward that end and fills the vacated slot with 0.
  assign first_bit  = MSB_FIRST ? load_if.load_data[W-1] : load_if.load_data[0];
  assign next_bit   = MSB_FIRST ? sr_q[W-2] : sr_q[1];
  assign sr_shifted = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    if (clr_i) begin
      state_d = StIdle;
      sout_d  = SOUT_IDLE;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_if.load_valid) begin
            sr_d    = load_if.load_data;
            sout_d  = first_bit;
            state_d = StShift;
          end
        end
        StShift: begin
          if (e_i) begin
            if (cnt_last) begin
              state_d = StIdle;
              sout_d  = SOUT_IDLE;
              done_d  = 1'b1;
            end else begin
              sr_d   = sr_shifted;
              sout_d = next_bit;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      sout_q  <= SOUT_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign load_if.load_ready = (state_q == StIdle);
  assign busy_o             = (state_q == StShift);
  assign sout_o             = sout_q;
  assign done_o             = done_q;

  cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n) cnt <= CntMax);
  cnt_zero_idle: assert property (@(posedge clk) disable iff (!rst_n)
                                  (state_q == StIdle) |-> (cnt == '0));

endmodule
